watch_set_ctrl: RTL and testbench

Time-set controller for the digital watch. Turns two debounced push-buttons into the `mode`, `change_*` and `valid_response` controls that the hour, minute and second counters consume. It sequences field selection, generates single and auto-repeat increment pulses, and drives a blink enable for the display. It also returns to run mode after an idle timeout. It sits between the button debouncers and the time-counter chain.

---
 rtl/watch_set_ctrl_pkg.sv | 34 +++
 rtl/watch_set_ctrl_btn_edge.sv | 24 ++
 rtl/watch_set_ctrl.sv | 130 +++++++++++++
 tb/tb_watch_set_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/watch_set_ctrl_pkg.sv
// watch_pkg: shared definitions for the watch time-set controller.
// Holds the field/state encoding, the system clock rate and the default
// timing parameters used by watch_set_ctrl.
package watch_pkg;

    localparam int unsigned CLK_HZ            = 100_000_000;
    localparam int unsigned REPEAT_DELAY_DEF  = 50_000_000;
    localparam int unsigned REPEAT_PERIOD_DEF = 20_000_000;
    localparam int unsigned TIMEOUT_DEF       = 1_000_000_000;
    localparam int unsigned BLINK_HALF_DEF    = 25_000_000;

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] SET_HOUR = 2'd1;
    localparam logic [1:0] SET_MIN  = 2'd2;
    localparam logic [1:0] SET_SEC  = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN  = RUN,
        ST_HOUR = SET_HOUR,
        ST_MIN  = SET_MIN,
        ST_SEC  = SET_SEC
    } state_t;

    // Mode-button sequence: RUN -> HOUR -> MIN -> SEC -> RUN
    function automatic state_t next_field(input state_t s);
        case (s)
            ST_RUN:  return ST_HOUR;
            ST_HOUR: return ST_MIN;
            ST_MIN:  return ST_SEC;
            default: return ST_RUN;
        endcase
    endfunction

endpackage

// File: rtl/watch_set_ctrl_btn_edge.sv
// btn_edge: rising-edge detector for a debounced level button.
// Ports: clk, rst (sync, active-low), btn (level in), rise_c (combinational
// one-cycle rise indication). The history register resets to 1 so a button
// already held through reset never reports a rise.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise_c
);

    logic prev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev <= 1'b1;
        end else begin
            prev <= btn;
        end
    end

    assign rise_c = btn & ~prev;

endmodule

// File: rtl/watch_set_ctrl.sv
// watch_set_ctrl: time-set controller for the digital watch.
// Ports: clk, rst (sync, active-low), btn_mode / btn_inc (debounced level
// buttons); registered outputs mode, change_hour/minute/second (one-hot field
// select), valid_response (one-cycle increment strobe), blink (display
// enable for the selected field) and field (state encoding).
module watch_set_ctrl
    import watch_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF,
    parameter int unsigned TIMEOUT       = TIMEOUT_DEF,
    parameter int unsigned BLINK_HALF    = BLINK_HALF_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       mode,
    output logic       change_hour,
    output logic       change_minute,
    output logic       change_second,
    output logic       valid_response,
    output logic       blink,
    output logic [1:0] field
);

    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW      = $clog2(REP_MAX);
    localparam int unsigned TW      = $clog2(TIMEOUT);
    localparam int unsigned BW      = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;

    logic rise_mode_c;
    logic rise_inc_c;

    state_t        state,    state_n;
    logic [RW-1:0] rep_cnt,  rep_cnt_n;
    logic          rep_on,   rep_on_n;    // an initial pulse armed auto-repeat
    logic          rep_per,  rep_per_n;   // 0: waiting first delay, 1: periodic
    logic [TW-1:0] idle_cnt, idle_n;
    logic [BW-1:0] blk_cnt,  blk_n;
    logic          blink_n;
    logic          valid_n;

    btn_edge u_edge_mode (.clk(clk), .rst(rst), .btn(btn_mode), .rise_c(rise_mode_c));
    btn_edge u_edge_inc  (.clk(clk), .rst(rst), .btn(btn_inc),  .rise_c(rise_inc_c));

    // Next state: mode rise > timeout > increment / repeat
    always_comb begin
        state_n   = state;
        valid_n   = 1'b0;
        rep_cnt_n = '0;
        rep_on_n  = 1'b0;
        rep_per_n = 1'b0;
        idle_n    = '0;
        blink_n   = 1'b0;
        blk_n     = '0;

        if (rise_mode_c) begin
            state_n = next_field(state);
            blink_n = (state_n != ST_RUN);
        end else if (state != ST_RUN) begin
            if (idle_cnt == TW'(TIMEOUT - 1)) begin
                state_n = ST_RUN;
            end else begin
                // Holding inc counts as activity, so it also blocks the timeout
                if (!btn_inc) begin
                    idle_n = (idle_cnt == '1) ? idle_cnt : idle_cnt + 1'b1;
                end

                if (rise_inc_c) begin
                    valid_n  = 1'b1;
                    rep_on_n = 1'b1;
                end else if (btn_inc && rep_on) begin
                    rep_on_n  = 1'b1;
                    rep_per_n = rep_per;
                    if (rep_cnt == (rep_per ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1))) begin
                        valid_n   = 1'b1;
                        rep_per_n = 1'b1;
                    end else begin
                        rep_cnt_n = (rep_cnt == '1) ? rep_cnt : rep_cnt + 1'b1;
                    end
                end

                // Increment restarts the visible half so the field stays shown
                if (valid_n) begin
                    blink_n = 1'b1;
                end else if (blk_cnt == BW'(BLINK_HALF - 1)) begin
                    blink_n = ~blink;
                end else begin
                    blink_n = blink;
                    blk_n   = (blk_cnt == '1) ? blk_cnt : blk_cnt + 1'b1;
                end
            end
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= ST_RUN;
            rep_cnt        <= '0;
            rep_on         <= 1'b0;
            rep_per        <= 1'b0;
            idle_cnt       <= '0;
            blk_cnt        <= '0;
            mode           <= 1'b0;
            change_hour    <= 1'b0;
            change_minute  <= 1'b0;
            change_second  <= 1'b0;
            valid_response <= 1'b0;
            blink          <= 1'b0;
            field          <= RUN;
        end else begin
            state          <= state_n;
            rep_cnt        <= rep_cnt_n;
            rep_on         <= rep_on_n;
            rep_per        <= rep_per_n;
            idle_cnt       <= idle_n;
            blk_cnt        <= blk_n;
            mode           <= (state_n != ST_RUN);
            change_hour    <= (state_n == ST_HOUR);
            change_minute  <= (state_n == ST_MIN);
            change_second  <= (state_n == ST_SEC);
            valid_response <= valid_n;
            blink          <= blink_n;
            field          <= state_n;
        end
    end

endmodule

// File: tb/tb_watch_set_ctrl.sv
// tb_watch_set_ctrl: scenario bench for watch_set_ctrl with short timing
// parameters. Each cycle the expected field and strobe are queued as the
// buttons are driven, then popped and compared after the sampling edge.
module tb_watch_set_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_mode = 1'b1;
    logic       btn_inc  = 1'b1;
    logic       mode;
    logic       change_hour;
    logic       change_minute;
    logic       change_second;
    logic       valid_response;
    logic       blink;
    logic [1:0] field;

    typedef struct packed {
        logic [1:0] field;
        logic       valid;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    watch_set_ctrl #(
        .REPEAT_DELAY (8),
        .REPEAT_PERIOD(4),
        .TIMEOUT      (32),
        .BLINK_HALF   (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_mode      (btn_mode),
        .btn_inc       (btn_inc),
        .mode          (mode),
        .change_hour   (change_hour),
        .change_minute (change_minute),
        .change_second (change_second),
        .valid_response(valid_response),
        .blink         (blink),
        .field         (field)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Drive buttons for one edge, queue expectation, check the result after the edge
    task automatic step(input logic bm, input logic bi, input logic [1:0] ef, input logic ev);
        exp_t e;
        @(negedge clk);
        btn_mode = bm;
        btn_inc  = bi;
        q.push_back('{field: ef, valid: ev});
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("field", 8'(field), 8'(e.field));
        chk("mode", 8'(mode), 8'(e.field != 2'd0));
        chk("change_hour", 8'(change_hour), 8'(e.field == 2'd1));
        chk("change_minute", 8'(change_minute), 8'(e.field == 2'd2));
        chk("change_second", 8'(change_second), 8'(e.field == 2'd3));
        chk("valid_response", 8'(valid_response), 8'(e.valid));
        if (e.field == 2'd0) chk("blink_run", 8'(blink), 8'd0);
    endtask

    task automatic press(input logic [1:0] ef);
        step(1'b1, 1'b0, ef, 1'b0);
        step(1'b1, 1'b0, ef, 1'b0);
        step(1'b0, 1'b0, ef, 1'b0);
    endtask

    initial begin
        // Reset with both buttons held, then release reset with them still held
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'd0, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'd0, 1'b0);
        step(1'b0, 1'b0, 2'd0, 1'b0);

        // Field sequencing
        press(2'd1);
        press(2'd2);
        press(2'd3);
        press(2'd0);

        // Auto-repeat in SET_MIN: pulses after edges 0, 8, 12, 16, 20
        press(2'd1);
        press(2'd2);
        for (int k = 0; k <= 20; k++)
            step(1'b0, 1'b1, 2'd2, (k == 0) || (k == 8) || (k == 12) || (k == 16) || (k == 20));
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 2'd2, 1'b0);

        // Timeout from SET_SEC 32 edges after entry, blink half-period 5
        for (int k = 0; k <= 32; k++) begin
            step(k < 2, 1'b0, (k == 32) ? 2'd0 : 2'd3, 1'b0);
            if (k < 20) chk("blink_phase", 8'(blink), 8'(((k / 5) % 2) == 0));
        end

        // An inc press at edge 20 restarts the idle count
        press(2'd1);
        press(2'd2);
        for (int k = 0; k <= 52; k++) begin
            step(k < 2, k == 20, (k == 52) ? 2'd0 : 2'd3, k == 20);
            if (k == 20) chk("blink_on_inc", 8'(blink), 8'd1);
        end

        // Simultaneous mode+inc rise in SET_HOUR: advance only, no armed repeat
        press(2'd1);
        step(1'b1, 1'b1, 2'd2, 1'b0);
        step(1'b1, 1'b1, 2'd2, 1'b0);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 2'd2, 1'b0);
        step(1'b0, 1'b0, 2'd2, 1'b0);
        press(2'd3);
        press(2'd0);

        // Inc in RUN is ignored
        step(1'b0, 1'b1, 2'd0, 1'b0);
        step(1'b0, 1'b1, 2'd0, 1'b0);
        step(1'b0, 1'b0, 2'd0, 1'b0);

        // Reset during auto-repeat in SET_SEC
        press(2'd1);
        press(2'd2);
        press(2'd3);
        for (int k = 0; k <= 10; k++) step(1'b0, 1'b1, 2'd3, (k == 0) || (k == 8));
        rst = 1'b0;
        step(1'b0, 1'b1, 2'd0, 1'b0);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 2'd0, 1'b0);
        for (int f = 1; f <= 3; f++) begin
            step(1'b1, 1'b1, 2'(f), 1'b0);
            step(1'b1, 1'b1, 2'(f), 1'b0);
            step(1'b0, 1'b1, 2'(f), 1'b0);
        end
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 2'd3, 1'b0);
        step(1'b0, 1'b0, 2'd3, 1'b0);
        step(1'b0, 1'b1, 2'd3, 1'b1);
        step(1'b0, 1'b0, 2'd3, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
